// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready operation and result bundle for the pipelined barrel shifter.
// The master modport drives operations in and accepts results; the slave modport is the shifter side.
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [2:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;
    logic               out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined log barrel shifter: one registered stage per shift-amount bit, global stall,
// five shift/rotate modes plus a pass-through error path for reserved modes.
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    barrel_shift_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = SHAMT_W - 1;

    typedef logic [WIDTH-1:0] word_t;

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("barrel_shift_pipe: WIDTH must be a power of two and >= 4");
    end

    logic               valid_reg  [SHAMT_W];
    word_t              data_reg   [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_reg  [SHAMT_W];
    logic [2:0]         mode_reg   [SHAMT_W];
    logic [TAG_W-1:0]   tag_reg    [SHAMT_W];
    logic               msb_reg    [SHAMT_W];

    logic               valid_next [SHAMT_W];
    word_t              data_next  [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_next [SHAMT_W];
    logic [2:0]         mode_next  [SHAMT_W];
    logic [TAG_W-1:0]   tag_next   [SHAMT_W];
    logic               msb_next   [SHAMT_W];

    logic stall;

    function automatic word_t step(input word_t d, input logic [2:0] mode,
                                   input logic fill, input int unsigned amt);
        word_t fill_mask;
        fill_mask = ~(~word_t'(0) >> amt);
        case (mode)
            3'b000:  return d << amt;
            3'b001:  return d >> amt;
            3'b010:  return (d >> amt) | (fill ? fill_mask : word_t'(0));
            3'b011:  return (d << amt) | (d >> (WIDTH - amt));
            3'b100:  return (d >> amt) | (d << (WIDTH - amt));
            default: return d;
        endcase
    endfunction

    // The carried shamt is shifted down one bit per stage so every stage tests bit 0.
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        logic               src_valid;
        word_t              src_data;
        logic [SHAMT_W-1:0] src_shamt;
        logic [2:0]         src_mode;
        logic [TAG_W-1:0]   src_tag;
        logic               src_msb;

        if (gi == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_data  = bus.in_data;
            assign src_shamt = bus.in_shamt;
            assign src_mode  = bus.in_mode;
            assign src_tag   = bus.in_tag;
            assign src_msb   = bus.in_data[WIDTH-1];
        end else begin : g_body
            assign src_valid = valid_reg[gi-1];
            assign src_data  = data_reg[gi-1];
            assign src_shamt = shamt_reg[gi-1];
            assign src_mode  = mode_reg[gi-1];
            assign src_tag   = tag_reg[gi-1];
            assign src_msb   = msb_reg[gi-1];
        end

        assign valid_next[gi] = src_valid;
        assign data_next[gi]  = src_shamt[0] ? step(src_data, src_mode, src_msb, 1 << gi) : src_data;
        assign shamt_next[gi] = src_shamt >> 1;
        assign mode_next[gi]  = src_mode;
        assign tag_next[gi]   = src_tag;
        assign msb_next[gi]   = src_msb;
    end

    assign stall = valid_reg[LAST] && !bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHAMT_W; i++) begin
                valid_reg[i] <= 1'b0;
                data_reg[i]  <= '0;
                shamt_reg[i] <= '0;
                mode_reg[i]  <= '0;
                tag_reg[i]   <= '0;
                msb_reg[i]   <= 1'b0;
            end
        end else if (!stall) begin
            for (int i = 0; i < SHAMT_W; i++) begin
                valid_reg[i] <= valid_next[i];
                data_reg[i]  <= data_next[i];
                shamt_reg[i] <= shamt_next[i];
                mode_reg[i]  <= mode_next[i];
                tag_reg[i]   <= tag_next[i];
                msb_reg[i]   <= msb_next[i];
            end
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = valid_reg[LAST];
    assign bus.out_data  = data_reg[LAST];
    assign bus.out_tag   = tag_reg[LAST];
    // Gated by valid so the flags read 0 while the pipe is empty or in reset.
    assign bus.out_zero  = valid_reg[LAST] && (data_reg[LAST] == '0);
    assign bus.out_err   = valid_reg[LAST] && (mode_reg[LAST] > 3'd4);
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe: expected results are queued on input acceptance
// and compared in order as results transfer out.
module tb_barrel_shift_pipe;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
    barrel_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] tag;
        logic       zero;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [3:0] prev_tag;

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m);
        int sh;
        sh = int'(s);
        case (m)
            SLL:     return d << sh;
            SRL:     return d >> sh;
            SRA:     return 8'($signed(d) >>> sh);
            ROL:     return (d << sh) | (d >> (8 - sh));
            ROR:     return (d >> sh) | (d << (8 - sh));
            default: return d;
        endcase
    endfunction

    // Output monitor: in-order scoreboard pop plus hold-while-stalled check.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_tag !== prev_tag) begin
                    miscompares++;
                    $display("FAIL hold: valid=%b data=%h tag=%h, required valid=1 data=%h tag=%h",
                             bus.out_valid, bus.out_data, bus.out_tag, prev_data, prev_tag);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: data=%h tag=%h with empty scoreboard", bus.out_data, bus.out_tag);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_data, bus.out_tag, bus.out_zero, bus.out_err} !== {e.data, e.tag, e.zero, e.err}) begin
                        miscompares++;
                        $display("FAIL result: data=%h tag=%h zero=%b err=%b, required data=%h tag=%h zero=%b err=%b",
                                 bus.out_data, bus.out_tag, bus.out_zero, bus.out_err, e.data, e.tag, e.zero, e.err);
                    end else begin
                        $display("result ok: data=%h tag=%h zero=%b err=%b", e.data, e.tag, e.zero, e.err);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_tag   = bus.out_tag;
        end
    end

    // Presents one op from posedge+1, waits for acceptance, returns at the next posedge+1.
    task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                         input logic [3:0] t, input logic [7:0] e);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_mode  = m;
        bus.in_tag   = t;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 100 cycles", bus.in_ready);
        end else begin
            sb.push_back('{data: e, tag: t, zero: (e == 8'h00), err: (m > 3'd4)});
            $display("op in: data=%h shamt=%0d mode=%0d tag=%h expect=%h", d, s, m, t, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_shamt = 3'($urandom);
        bus.in_mode  = 3'($urandom);
        bus.in_tag   = 4'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        idle();
        #1;
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_tag, bus.out_zero, bus.out_err} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h tag=%h zero=%b err=%b, required 0 1 00 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_data, bus.out_tag, bus.out_zero, bus.out_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sll();
        int n = 0;
        drive(8'hFF, 3'd3, SLL, 4'h5, 8'hF8);
        idle();
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL latency: %0d cycles, required 3", n);
        end
        wait_drain();
        drive(8'hFF, 3'd0, SLL, 4'h1, 8'hFF);
        drive(8'hFF, 3'd5, SLL, 4'h2, 8'hE0);
        drive(8'hFF, 3'd7, SLL, 4'h3, 8'h80);
        idle();
        wait_drain();
    endtask

    task automatic test_shift_right();
        drive(8'h80, 3'd7, SRL, 4'h4, 8'h01);
        drive(8'h80, 3'd7, SRA, 4'h5, 8'hFF);
        drive(8'h70, 3'd4, SRA, 4'h6, 8'h07);
        drive(8'h01, 3'd1, SRL, 4'h7, 8'h00);
        idle();
        wait_drain();
    endtask

    task automatic test_rotate();
        drive(8'h81, 3'd1, ROL, 4'h8, 8'h03);
        drive(8'h01, 3'd1, ROR, 4'h9, 8'h80);
        drive(8'hA5, 3'd4, ROL, 4'hA, 8'h5A);
        drive(8'h3C, 3'd2, 3'b111, 4'hB, 8'h3C);
        drive(8'h96, 3'd0, ROR, 4'hC, 8'h96);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] d;
                    logic [2:0] s, m;
                    d = 8'($urandom);
                    s = 3'($urandom);
                    m = 3'(i % 5);
                    drive(d, s, m, 4'(i), model(d, s, m));
                end
                idle();
            end
            begin
                int n = 0;
                int run = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.out_valid && n < 30);
                vectors++;
                if (n != 4) begin
                    miscompares++;
                    $display("FAIL b2b_start: first result at cycle %0d, required 4", n);
                end
                run = 1;
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) run++;
                end
                @(negedge clk);
                vectors++;
                if (run != 8 || bus.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_run: %0d consecutive valid then valid=%b, required 8 then 0", run, bus.out_valid);
                end
            end
        join
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] hd;
        logic [3:0] ht;
        bus.out_ready = 1'b0;
        drive(8'h0F, 3'd1, SLL, 4'h1, 8'h1E);
        drive(8'hC3, 3'd2, ROR, 4'h2, 8'hF0);
        drive(8'h90, 3'd3, SRA, 4'h3, 8'hF2);
        fork
            drive(8'h11, 3'd4, ROL, 4'h4, 8'h11);
            begin
                @(negedge clk);
                hd = bus.out_data;
                ht = bus.out_tag;
                for (int i = 0; i < 5; i++) begin
                    vectors++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_tag !== ht) begin
                        miscompares++;
                        $display("FAIL stall: ready=%b valid=%b data=%h tag=%h, required 0 1 %h %h",
                                 bus.in_ready, bus.out_valid, bus.out_data, bus.out_tag, hd, ht);
                    end
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle();
        wait_drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] d;
                    logic [2:0] s, m;
                    d = 8'($urandom);
                    s = 3'($urandom);
                    m = 3'($urandom);
                    drive(d, s, m, 4'(i), model(d, s, m));
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !done; c++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        bus.out_ready = 1'b1;
        drive(8'h12, 3'd1, SLL, 4'h1, 8'h24);
        drive(8'h34, 3'd2, SRL, 4'h2, 8'h0D);
        drive(8'h56, 3'd3, ROL, 4'h3, 8'hB2);
        idle();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ready=%b data=%h, required 0 1 00", bus.out_valid, bus.in_ready, bus.out_data);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive(8'h01, 3'd2, SLL, 4'hD, 8'h04);
        idle();
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL reset_latency: %0d cycles, required 3", n);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_sll();
        test_shift_right();
        test_rotate();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
